// File: rtl/seg7_capture.sv
// Purpose : reconstruct per-digit value/dp/blank/error from a scanned 7-segment bus,
//           committing a digit only after STABLE identical qualifying samples.
// Latency : commit registered on the STABLE-th matching sample edge; o_upd pulses the next cycle.
// Backpressure: none; samples arrive on i_sample ticks and are never stalled.
// Ports   : i_clk/i_rstn clock and async active-low reset; i_sample sample tick;
//           i_dig one-hot digit strobe; i_seg/i_dp segment and decimal-point lines;
//           o_val/o_dp/o_blank/o_err committed per-digit state; o_upd per-digit commit pulse.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_sample,
  input  logic [NDIG-1:0]   i_dig,
  input  logic [6:0]        i_seg,
  input  logic              i_dp,
  output logic [4*NDIG-1:0] o_val,
  output logic [NDIG-1:0]   o_dp,
  output logic [NDIG-1:0]   o_blank,
  output logic [NDIG-1:0]   o_err,
  output logic [NDIG-1:0]   o_upd
);

  localparam int CW = $clog2(STABLE + 1);

  logic [7:0] w_pat;
  logic       w_valid;
  logic       w_legal;
  logic       w_blank;
  logic [3:0] w_glyph;

  assign w_pat = {i_seg, i_dp};
  // Zero or multi-hot strobes are discarded entirely.
  assign w_valid = i_sample && $onehot(i_dig);

  // Glyph decode of the incoming segments; shared by all digits because the
  // committed pattern is always the one sampled on the commit edge.
  always_comb begin
    w_legal = 1'b1;
    w_blank = 1'b0;
    w_glyph = 4'h0;
    case (i_seg)
      7'h3F: w_glyph = 4'h0;
      7'h06: w_glyph = 4'h1;
      7'h5B: w_glyph = 4'h2;
      7'h4F: w_glyph = 4'h3;
      7'h66: w_glyph = 4'h4;
      7'h6D: w_glyph = 4'h5;
      7'h7D: w_glyph = 4'h6;
      7'h07: w_glyph = 4'h7;
      7'h7F: w_glyph = 4'h8;
      7'h6F: w_glyph = 4'h9;
      7'h77: w_glyph = 4'hA;
      7'h7C: w_glyph = 4'hB;
      7'h39: w_glyph = 4'hC;
      7'h5E: w_glyph = 4'hD;
      7'h79: w_glyph = 4'hE;
      7'h71: w_glyph = 4'hF;
      7'h00: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    logic [7:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_val;
    logic          r_dp;
    logic          r_blank;
    logic          r_err;
    logic          r_upd;
    logic          w_hit;
    logic          w_same;
    logic          w_commit;

    assign w_hit  = w_valid && i_dig[k];
    assign w_same = (w_pat == r_cand);
    // A match commits on the STABLE-1 -> STABLE step; a fresh pattern
    // commits immediately only when a single sample is enough.
    assign w_commit = w_hit && (w_same ? (r_cnt == CW'(STABLE - 1)) : (STABLE == 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        r_cand  <= 8'h00;
        r_cnt   <= '0;
        r_val   <= 4'h0;
        r_dp    <= 1'b0;
        r_blank <= 1'b1;
        r_err   <= 1'b0;
        r_upd   <= 1'b0;
      end else begin
        r_upd <= w_commit;
        if (w_hit) begin
          if (w_same) begin
            if (r_cnt != CW'(STABLE)) r_cnt <= CW'(r_cnt + 1'b1);
          end else begin
            r_cand <= w_pat;
            r_cnt  <= CW'(1);
          end
        end
        if (w_commit) begin
          r_dp <= i_dp;
          if (w_legal) begin
            r_val   <= w_glyph;
            r_blank <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_blank) begin
            r_val   <= 4'h0;
            r_blank <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            // Illegal glyph keeps the last good value visible.
            r_blank <= 1'b0;
            r_err   <= 1'b1;
          end
        end
      end
    end

    assign o_val[4*k +: 4] = r_val;
    assign o_dp[k]         = r_dp;
    assign o_blank[k]      = r_blank;
    assign o_err[k]        = r_err;
    assign o_upd[k]        = r_upd;
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_sample;
  logic [3:0]  i_dig;
  logic [6:0]  i_seg;
  logic        i_dp;
  logic [15:0] o_val;
  logic [3:0]  o_dp;
  logic [3:0]  o_blank;
  logic [3:0]  o_err;
  logic [3:0]  o_upd;

  int checks = 0;
  int failures = 0;

  seg7_capture #(.NDIG(4), .STABLE(3)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_sample(i_sample), .i_dig(i_dig),
    .i_seg(i_seg), .i_dp(i_dp), .o_val(o_val), .o_dp(o_dp),
    .o_blank(o_blank), .o_err(o_err), .o_upd(o_upd)
  );

  always #5 i_clk = ~i_clk;

  // One qualifying sample edge; returns 1 time unit after the edge.
  task automatic do_sample(input logic [3:0] dig, input logic [6:0] seg, input logic dp);
    i_dig = dig; i_seg = seg; i_dp = dp; i_sample = 1'b1;
    @(posedge i_clk); #1;
    i_sample = 1'b0;
  endtask

  task automatic idle();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_sample = 1'b0; i_dig = 4'h0; i_seg = 7'h00; i_dp = 1'b0;
    #12;
    checks++; if (o_blank !== 4'hF) begin failures++; $display("FAIL rst_blank got=%h exp=F", o_blank); end
    checks++; if (o_val !== 16'h0000) begin failures++; $display("FAIL rst_val got=%h exp=0000", o_val); end
    checks++; if (o_dp !== 4'h0) begin failures++; $display("FAIL rst_dp got=%b exp=0000", o_dp); end
    checks++; if (o_err !== 4'h0) begin failures++; $display("FAIL rst_err got=%b exp=0000", o_err); end
    checks++; if (o_upd !== 4'h0) begin failures++; $display("FAIL rst_upd got=%b exp=0000", o_upd); end
    i_rstn = 1'b1;
    idle();
  endtask

  task automatic test_debounce();
    do_sample(4'b0001, 7'h5B, 1'b0);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL deb_s1_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0001, 7'h5B, 1'b0);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL deb_s2_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0001, 7'h5B, 1'b0);
    checks++; if (o_upd !== 4'b0001) begin failures++; $display("FAIL deb_s3_upd got=%b exp=0001", o_upd); end
    checks++; if (o_val !== 16'h0002) begin failures++; $display("FAIL deb_val got=%h exp=0002", o_val); end
    checks++; if (o_blank !== 4'hE) begin failures++; $display("FAIL deb_blank got=%h exp=E", o_blank); end
    idle();
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL deb_pulse_len got=%b exp=0000", o_upd); end
    do_sample(4'b0001, 7'h5B, 1'b0);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL deb_s4_upd got=%b exp=0000", o_upd); end
  endtask

  task automatic test_glitch();
    logic [6:0] seq [6] = '{7'h06, 7'h06, 7'h7F, 7'h06, 7'h06, 7'h06};
    for (int i = 0; i < 5; i++) begin
      do_sample(4'b0010, seq[i], 1'b0);
      checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL glitch_s%0d_upd got=%b exp=0000", i, o_upd); end
    end
    do_sample(4'b0010, seq[5], 1'b0);
    checks++; if (o_upd !== 4'b0010) begin failures++; $display("FAIL glitch_commit_upd got=%b exp=0010", o_upd); end
    checks++; if (o_val !== 16'h0012) begin failures++; $display("FAIL glitch_val got=%h exp=0012", o_val); end
    idle();
  endtask

  task automatic test_sweep();
    logic [6:0] pats [4] = '{7'h3F, 7'h4F, 7'h77, 7'h71};
    logic [3:0] seen;
    seen = 4'h0;
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        do_sample(4'(1 << d), pats[d], (d == 2));
        if (r < 2) seen = seen | o_upd;
        else begin
          checks++; if (o_upd !== 4'(1 << d)) begin failures++; $display("FAIL sweep_upd_d%0d got=%b exp=%b", d, o_upd, 4'(1 << d)); end
        end
      end
    end
    checks++; if (seen !== 4'h0) begin failures++; $display("FAIL sweep_early_commit got=%b exp=0000", seen); end
    checks++; if (o_val !== 16'hFA30) begin failures++; $display("FAIL sweep_val got=%h exp=FA30", o_val); end
    checks++; if (o_dp !== 4'b0100) begin failures++; $display("FAIL sweep_dp got=%b exp=0100", o_dp); end
    checks++; if (o_blank !== 4'h0 || o_err !== 4'h0) begin failures++; $display("FAIL sweep_flags got=%b/%b exp=0000/0000", o_blank, o_err); end
    idle();
  endtask

  task automatic test_illegal_blank();
    for (int i = 0; i < 3; i++) do_sample(4'b1000, 7'h49, 1'b0);
    checks++; if (o_upd !== 4'b1000) begin failures++; $display("FAIL ill_upd got=%b exp=1000", o_upd); end
    checks++; if (o_err !== 4'b1000) begin failures++; $display("FAIL ill_err got=%b exp=1000", o_err); end
    checks++; if (o_val !== 16'hFA30) begin failures++; $display("FAIL ill_val got=%h exp=FA30", o_val); end
    checks++; if (o_blank !== 4'b0000) begin failures++; $display("FAIL ill_blank got=%b exp=0000", o_blank); end
    for (int i = 0; i < 3; i++) do_sample(4'b1000, 7'h00, 1'b0);
    checks++; if (o_blank !== 4'b1000) begin failures++; $display("FAIL blk_blank got=%b exp=1000", o_blank); end
    checks++; if (o_err !== 4'b0000) begin failures++; $display("FAIL blk_err got=%b exp=0000", o_err); end
    checks++; if (o_val !== 16'h0A30) begin failures++; $display("FAIL blk_val got=%h exp=0A30", o_val); end
    idle();
  endtask

  task automatic test_bad_strobe();
    do_sample(4'b0100, 7'h6D, 1'b0);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL bad_v1_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0000, 7'h7F, 1'b1);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL bad_zero_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0100, 7'h6D, 1'b0);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL bad_v2_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0011, 7'h06, 1'b1);
    checks++; if (o_upd !== 4'b0000) begin failures++; $display("FAIL bad_multi_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0100, 7'h6D, 1'b0);
    checks++; if (o_upd !== 4'b0100) begin failures++; $display("FAIL bad_v3_upd got=%b exp=0100", o_upd); end
    checks++; if (o_val !== 16'h0530) begin failures++; $display("FAIL bad_val got=%h exp=0530", o_val); end
    checks++; if (o_dp !== 4'b0000) begin failures++; $display("FAIL bad_dp got=%b exp=0000", o_dp); end
    // Sample tick low: bus activity must be ignored.
    i_dig = 4'b0001; i_seg = 7'h06; i_dp = 1'b1; i_sample = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    checks++; if (o_val !== 16'h0530 || o_upd !== 4'h0 || o_dp !== 4'h0) begin
      failures++; $display("FAIL nosample_hold got=%h/%b/%b exp=0530/0000/0000", o_val, o_upd, o_dp);
    end
  endtask

  task automatic test_reset_mid();
    do_sample(4'b0001, 7'h06, 1'b0);
    do_sample(4'b0001, 7'h06, 1'b0);
    for (int i = 0; i < 3; i++) do_sample(4'b0010, 7'h5B, 1'b0);
    checks++; if (o_upd !== 4'b0010) begin failures++; $display("FAIL mid_pre_upd got=%b exp=0010", o_upd); end
    #1 i_rstn = 1'b0;
    #1;
    checks++; if (o_upd !== 4'h0) begin failures++; $display("FAIL mid_rst_upd got=%b exp=0000", o_upd); end
    checks++; if (o_blank !== 4'hF) begin failures++; $display("FAIL mid_rst_blank got=%h exp=F", o_blank); end
    checks++; if (o_val !== 16'h0000) begin failures++; $display("FAIL mid_rst_val got=%h exp=0000", o_val); end
    #3 i_rstn = 1'b1;
    idle();
    do_sample(4'b0001, 7'h06, 1'b0);
    checks++; if (o_upd !== 4'h0) begin failures++; $display("FAIL mid_s1_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0001, 7'h06, 1'b0);
    checks++; if (o_upd !== 4'h0) begin failures++; $display("FAIL mid_s2_upd got=%b exp=0000", o_upd); end
    do_sample(4'b0001, 7'h06, 1'b0);
    checks++; if (o_upd !== 4'b0001) begin failures++; $display("FAIL mid_s3_upd got=%b exp=0001", o_upd); end
    checks++; if (o_val !== 16'h0001) begin failures++; $display("FAIL mid_val got=%h exp=0001", o_val); end
    checks++; if (o_blank !== 4'hE) begin failures++; $display("FAIL mid_blank got=%h exp=E", o_blank); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_sweep();
    test_illegal_blank();
    test_bad_strobe();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
